// File: rtl/arm_reg_pkg.sv
// rtl/arm_reg_pkg.sv - ARM banked register file constants, exception lookups and physical index map
package arm_reg_pkg;

    localparam logic [4:0] MODE_USR = 5'h10;
    localparam logic [4:0] MODE_FIQ = 5'h11;
    localparam logic [4:0] MODE_IRQ = 5'h12;
    localparam logic [4:0] MODE_SVC = 5'h13;
    localparam logic [4:0] MODE_ABT = 5'h17;
    localparam logic [4:0] MODE_UND = 5'h1B;
    localparam logic [4:0] MODE_SYS = 5'h1F;

    // Physical GPR layout: 0..15 USR, 16..22 FIQ R8-R14, then R13/R14 pairs.
    localparam int         NUM_PHYS     = 31;
    localparam logic [4:0] PHYS_FIQ_R8  = 5'd16;
    localparam logic [4:0] PHYS_IRQ_R13 = 5'd23;
    localparam logic [4:0] PHYS_SVC_R13 = 5'd25;
    localparam logic [4:0] PHYS_ABT_R13 = 5'd27;
    localparam logic [4:0] PHYS_UND_R13 = 5'd29;

    localparam int         NUM_SPSR  = 5;
    localparam logic [2:0] SPSR_FIQ  = 3'd0;
    localparam logic [2:0] SPSR_IRQ  = 3'd1;
    localparam logic [2:0] SPSR_SVC  = 3'd2;
    localparam logic [2:0] SPSR_ABT  = 3'd3;
    localparam logic [2:0] SPSR_UND  = 3'd4;
    localparam logic [2:0] SPSR_NONE = 3'd7;

    typedef enum logic [2:0] {
        EXC_RST  = 3'd0,
        EXC_UND  = 3'd1,
        EXC_SWI  = 3'd2,
        EXC_PABT = 3'd3,
        EXC_DABT = 3'd4,
        EXC_IRQ  = 3'd5,
        EXC_FIQ  = 3'd6,
        EXC_RSVD = 3'd7
    } exc_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_SWITCH = 2'd2,
        ST_DONE   = 2'd3
    } exc_state_e;

    function automatic logic [4:0] exc_target_mode(input exc_code_e code);
        case (code)
            EXC_RST:  return MODE_SVC;
            EXC_SWI:  return MODE_SVC;
            EXC_PABT: return MODE_ABT;
            EXC_DABT: return MODE_ABT;
            EXC_IRQ:  return MODE_IRQ;
            EXC_FIQ:  return MODE_FIQ;
            default:  return MODE_UND;
        endcase
    endfunction

    function automatic logic [7:0] exc_vector_offset(input exc_code_e code);
        case (code)
            EXC_RST:  return 8'h00;
            EXC_SWI:  return 8'h08;
            EXC_PABT: return 8'h0C;
            EXC_DABT: return 8'h10;
            EXC_IRQ:  return 8'h18;
            EXC_FIQ:  return 8'h1C;
            default:  return 8'h04;
        endcase
    endfunction

    function automatic logic [2:0] spsr_index(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return SPSR_FIQ;
            MODE_IRQ: return SPSR_IRQ;
            MODE_SVC: return SPSR_SVC;
            MODE_ABT: return SPSR_ABT;
            MODE_UND: return SPSR_UND;
            default:  return SPSR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arm_bank_map.sv
// rtl/arm_bank_map.sv - logical register number plus CPSR mode to physical GPR index
module arm_bank_map
    import arm_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [4:0]            mode,
    output logic [4:0]            phys
);

    logic [3:0] reg_num;
    logic [4:0] hi_base;

    assign reg_num = 4'(addr);

    // SYS and unknown modes fall through to the USR bank.
    always_comb begin
        phys    = {1'b0, reg_num};
        hi_base = '0;
        case (mode)
            MODE_FIQ: begin
                if (reg_num >= 4'd8 && reg_num <= 4'd14) begin
                    phys = PHYS_FIQ_R8 + {1'b0, reg_num - 4'd8};
                end
            end
            MODE_IRQ: hi_base = PHYS_IRQ_R13;
            MODE_SVC: hi_base = PHYS_SVC_R13;
            MODE_ABT: hi_base = PHYS_ABT_R13;
            MODE_UND: hi_base = PHYS_UND_R13;
            default:  ;
        endcase
        if (hi_base != '0 && (reg_num == 4'd13 || reg_num == 4'd14)) begin
            phys = hi_base + {4'd0, reg_num == 4'd14};
        end
    end

endmodule

// File: rtl/arm_banked_regs.sv
// rtl/arm_banked_regs.sv - multi-port ARM banked register file with write bypass and exception sequencer
module arm_banked_regs
    import arm_reg_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 4,
    parameter int          NUM_READ    = 4,
    parameter int          NUM_WRITE   = 2,
    parameter int          MODE_WIDTH  = 5,
    parameter bit          BYPASS      = 1'b1,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]      r_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]      r_data,
    input  logic [NUM_WRITE-1:0]                w_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]     w_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]     w_data,
    input  logic [NUM_WRITE*(DATA_WIDTH/8)-1:0] w_byte_en,
    input  logic [DATA_WIDTH-1:0]               PC_in,
    input  logic                                PC_write_en,
    output logic [DATA_WIDTH-1:0]               PC_out,
    input  logic [DATA_WIDTH-1:0]               CPSR_in,
    input  logic                                CPSR_write_en,
    input  logic [DATA_WIDTH/8-1:0]             CPSR_byte_w_en,
    output logic [DATA_WIDTH-1:0]               CPSR_out,
    input  logic [DATA_WIDTH-1:0]               SPSR_in,
    input  logic                                SPSR_write_en,
    input  logic [DATA_WIDTH/8-1:0]             SPSR_byte_w_en,
    output logic [DATA_WIDTH-1:0]               SPSR_out,
    output logic [MODE_WIDTH-1:0]               Mode_out,
    input  logic                                exc_req,
    input  logic [2:0]                          exc_code,
    input  logic [DATA_WIDTH-1:0]               exc_lr,
    input  logic                                exc_ret_req,
    input  logic [DATA_WIDTH-1:0]               exc_ret_pc,
    output logic                                exc_busy,
    output logic                                exc_done
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] CPSR_RESET = DATA_WIDTH'(8'hD3);

    logic [DATA_WIDTH-1:0] gpr_q  [NUM_PHYS];
    logic [DATA_WIDTH-1:0] spsr_q [NUM_SPSR];
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] cpsr_q;
    exc_state_e            state_q, state_d;
    exc_code_e             exc_code_q;
    logic [DATA_WIDTH-1:0] exc_lr_q;

    logic [4:0]            cur_mode;
    logic [2:0]            cur_spsr_idx;
    logic [4:0]            tgt_mode;
    logic [2:0]            tgt_spsr_idx;
    logic [4:0]            lr_phys;
    logic                  ext_ok;
    logic                  ret_take;
    logic                  entry_take;
    logic [4:0]            r_phys [NUM_READ];
    logic [4:0]            w_phys [NUM_WRITE];
    logic [NUM_WRITE-1:0]  w_live;

    assign cur_mode     = cpsr_q[4:0];
    assign cur_spsr_idx = spsr_index(cur_mode);
    assign tgt_mode     = exc_target_mode(exc_code_q);
    assign tgt_spsr_idx = spsr_index(tgt_mode);
    assign ext_ok       = (state_q == ST_IDLE);
    assign entry_take   = ext_ok && exc_req;
    assign ret_take     = ext_ok && exc_ret_req && !exc_req;

    assign PC_out   = pc_q;
    assign CPSR_out = cpsr_q;
    assign Mode_out = cpsr_q[MODE_WIDTH-1:0];
    assign SPSR_out = (cur_spsr_idx == SPSR_NONE) ? '0 : spsr_q[cur_spsr_idx];

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rmap
        arm_bank_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_map (
            .addr (r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .mode (cur_mode),
            .phys (r_phys[i])
        );
    end

    for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wmap
        arm_bank_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_map (
            .addr (w_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .mode (cur_mode),
            .phys (w_phys[p])
        );
    end

    arm_bank_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_lr_map (
        .addr (ADDR_WIDTH'(14)),
        .mode (tgt_mode),
        .phys (lr_phys)
    );

    // R15 is never a GPR target; the PC moves only via PC_in or the sequencer.
    always_comb begin
        w_live = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            w_live[p] = ext_ok && w_en[p] &&
                        (w_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(15));
        end
    end

    // Ascending port order lets the highest-index enabled port win each byte.
    always_comb begin
        r_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            r_data[i*DATA_WIDTH +: DATA_WIDTH] = gpr_q[r_phys[i]];
            if (BYPASS) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_live[p] && w_phys[p] == r_phys[i] && w_byte_en[p*NB + b]) begin
                            r_data[i*DATA_WIDTH + b*8 +: 8] = w_data[p*DATA_WIDTH + b*8 +: 8];
                        end
                    end
                end
            end
            if (r_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(15)) begin
                r_data[i*DATA_WIDTH +: DATA_WIDTH] = pc_q;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        exc_busy = 1'b1;
        exc_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                exc_busy = 1'b0;
                if (exc_req) state_d = ST_SAVE;
            end
            ST_SAVE:   state_d = ST_SWITCH;
            ST_SWITCH: state_d = ST_DONE;
            ST_DONE: begin
                exc_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < NUM_PHYS; i++) gpr_q[i] <= '0;
            for (int i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
            pc_q       <= '0;
            cpsr_q     <= CPSR_RESET;
            exc_code_q <= EXC_RST;
            exc_lr_q   <= '0;
        end else begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_live[p] && w_byte_en[p*NB + b]) begin
                        gpr_q[w_phys[p]][b*8 +: 8] <= w_data[p*DATA_WIDTH + b*8 +: 8];
                    end
                end
            end
            if (ext_ok) begin
                if (PC_write_en) pc_q <= PC_in;
                for (int b = 0; b < NB; b++) begin
                    if (CPSR_write_en && CPSR_byte_w_en[b]) begin
                        cpsr_q[b*8 +: 8] <= CPSR_in[b*8 +: 8];
                    end
                    if (SPSR_write_en && SPSR_byte_w_en[b] && cur_spsr_idx != SPSR_NONE) begin
                        spsr_q[cur_spsr_idx][b*8 +: 8] <= SPSR_in[b*8 +: 8];
                    end
                end
            end
            // Placed after the plain writes so the return overrides them.
            if (ret_take) begin
                pc_q <= exc_ret_pc;
                if (cur_spsr_idx != SPSR_NONE) cpsr_q <= spsr_q[cur_spsr_idx];
            end
            if (entry_take) begin
                exc_code_q <= exc_code_e'(exc_code);
                exc_lr_q   <= exc_lr;
            end
            case (state_q)
                ST_SAVE: begin
                    spsr_q[tgt_spsr_idx] <= cpsr_q;
                    gpr_q[lr_phys]       <= exc_lr_q;
                end
                ST_SWITCH: begin
                    cpsr_q[4:0] <= tgt_mode;
                    cpsr_q[5]   <= 1'b0;
                    cpsr_q[7]   <= 1'b1;
                    if (exc_code_q == EXC_RST || exc_code_q == EXC_FIQ) cpsr_q[6] <= 1'b1;
                    pc_q <= DATA_WIDTH'(VECTOR_BASE) + DATA_WIDTH'(exc_vector_offset(exc_code_q));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_banked_regs.sv
// tb/tb_arm_banked_regs.sv - directed self-checking bench for arm_banked_regs
module tb_arm_banked_regs;

    logic         Clk;
    logic         Rst;
    logic [15:0]  r_addr;
    logic [127:0] r_data;
    logic [1:0]   w_en;
    logic [7:0]   w_addr;
    logic [63:0]  w_data;
    logic [7:0]   w_byte_en;
    logic [31:0]  PC_in;
    logic         PC_write_en;
    logic [31:0]  PC_out;
    logic [31:0]  CPSR_in;
    logic         CPSR_write_en;
    logic [3:0]   CPSR_byte_w_en;
    logic [31:0]  CPSR_out;
    logic [31:0]  SPSR_in;
    logic         SPSR_write_en;
    logic [3:0]   SPSR_byte_w_en;
    logic [31:0]  SPSR_out;
    logic [4:0]   Mode_out;
    logic         exc_req;
    logic [2:0]   exc_code;
    logic [31:0]  exc_lr;
    logic         exc_ret_req;
    logic [31:0]  exc_ret_pc;
    logic         exc_busy;
    logic         exc_done;

    int n_cmp;
    int n_fail;

    arm_banked_regs dut (
        .Clk(Clk), .Rst(Rst),
        .r_addr(r_addr), .r_data(r_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_byte_en(w_byte_en),
        .PC_in(PC_in), .PC_write_en(PC_write_en), .PC_out(PC_out),
        .CPSR_in(CPSR_in), .CPSR_write_en(CPSR_write_en), .CPSR_byte_w_en(CPSR_byte_w_en), .CPSR_out(CPSR_out),
        .SPSR_in(SPSR_in), .SPSR_write_en(SPSR_write_en), .SPSR_byte_w_en(SPSR_byte_w_en), .SPSR_out(SPSR_out),
        .Mode_out(Mode_out),
        .exc_req(exc_req), .exc_code(exc_code), .exc_lr(exc_lr),
        .exc_ret_req(exc_ret_req), .exc_ret_pc(exc_ret_pc),
        .exc_busy(exc_busy), .exc_done(exc_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        w_en = '0; w_addr = '0; w_data = '0; w_byte_en = '0;
        PC_in = '0; PC_write_en = 1'b0;
        CPSR_in = '0; CPSR_write_en = 1'b0; CPSR_byte_w_en = 4'hF;
        SPSR_in = '0; SPSR_write_en = 1'b0; SPSR_byte_w_en = 4'hF;
        exc_req = 1'b0; exc_code = '0; exc_lr = '0;
        exc_ret_req = 1'b0; exc_ret_pc = '0;
    endtask

    task automatic cpsr_set(input logic [31:0] v);
        CPSR_in = v; CPSR_write_en = 1'b1; CPSR_byte_w_en = 4'hF;
        tick();
        CPSR_write_en = 1'b0;
    endtask

    task automatic wr0(input logic [3:0] a, input logic [31:0] d);
        w_en = 2'b01; w_addr[3:0] = a; w_data[31:0] = d; w_byte_en[3:0] = 4'hF;
        tick();
        w_en = '0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        r_addr = {4'd15, 4'd13, 4'd1, 4'd0};
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++; if (CPSR_out !== 32'hD3) begin n_fail++; $display("FAIL reset_cpsr: got %h expected %h", CPSR_out, 32'hD3); end
        n_cmp++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", PC_out); end
        n_cmp++; if (r_data !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", r_data); end
        n_cmp++; if (exc_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", exc_busy); end
        n_cmp++; if (Mode_out !== 5'h13) begin n_fail++; $display("FAIL reset_mode: got %h expected 13", Mode_out); end
        Rst = 1'b1;
        tick();
        n_cmp++; if (exc_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", exc_done); end
        n_cmp++; if (SPSR_out !== 32'h0) begin n_fail++; $display("FAIL reset_spsr: got %h expected 0", SPSR_out); end
    endtask

    task automatic test_banking();
        cpsr_set(32'h10);
        n_cmp++; if (Mode_out !== 5'h10) begin n_fail++; $display("FAIL bank_mode_usr: got %h expected 10", Mode_out); end
        wr0(4'd13, 32'h1111);
        wr0(4'd8, 32'h88);
        cpsr_set(32'h12);
        wr0(4'd13, 32'h2222);
        r_addr = {4'd15, 4'd15, 4'd8, 4'd13};
        #1;
        n_cmp++; if (r_data[31:0] !== 32'h2222) begin n_fail++; $display("FAIL bank_irq_r13: got %h expected 2222", r_data[31:0]); end
        n_cmp++; if (r_data[63:32] !== 32'h88) begin n_fail++; $display("FAIL bank_irq_r8: got %h expected 88", r_data[63:32]); end
        cpsr_set(32'h10);
        n_cmp++; if (r_data[31:0] !== 32'h1111) begin n_fail++; $display("FAIL bank_usr_r13: got %h expected 1111", r_data[31:0]); end
        cpsr_set(32'h11);
        n_cmp++; if (r_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL bank_fiq_r8: got %h expected 0", r_data[63:32]); end
        n_cmp++; if (r_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL bank_fiq_r13: got %h expected 0", r_data[31:0]); end
        wr0(4'd15, 32'hDEAD);
        n_cmp++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL r15_write_pc: got %h expected 0", PC_out); end
        n_cmp++; if (r_data[95:64] !== 32'h0) begin n_fail++; $display("FAIL r15_read: got %h expected 0", r_data[95:64]); end
        cpsr_set(32'h10);
    endtask

    task automatic test_bypass();
        r_addr = {4'd0, 4'd0, 4'd4, 4'd3};
        w_en = 2'b11; w_addr = {4'd3, 4'd3};
        w_data = {32'h000000BB, 32'hAAAAAAAA}; w_byte_en = {4'b0001, 4'b1111};
        #1;
        n_cmp++; if (r_data[31:0] !== 32'hAAAAAABB) begin n_fail++; $display("FAIL bypass_r3: got %h expected AAAAAABB", r_data[31:0]); end
        tick();
        w_en = '0;
        #1;
        n_cmp++; if (r_data[31:0] !== 32'hAAAAAABB) begin n_fail++; $display("FAIL stored_r3: got %h expected AAAAAABB", r_data[31:0]); end
        w_en = 2'b11; w_addr = {4'd4, 4'd4};
        w_data = {32'hAABBCCDD, 32'h11223344}; w_byte_en = {4'b0110, 4'b0011};
        #1;
        n_cmp++; if (r_data[63:32] !== 32'h00BBCC44) begin n_fail++; $display("FAIL bypass_r4: got %h expected 00BBCC44", r_data[63:32]); end
        tick();
        w_en = '0;
        #1;
        n_cmp++; if (r_data[63:32] !== 32'h00BBCC44) begin n_fail++; $display("FAIL stored_r4: got %h expected 00BBCC44", r_data[63:32]); end
    endtask

    task automatic test_irq_entry();
        r_addr = {4'd0, 4'd0, 4'd0, 4'd14};
        exc_req = 1'b1; exc_code = 3'd5; exc_lr = 32'h104;
        tick();
        n_cmp++; if (exc_busy !== 1'b1) begin n_fail++; $display("FAIL irq_busy_e0: got %b expected 1", exc_busy); end
        n_cmp++; if (exc_done !== 1'b0) begin n_fail++; $display("FAIL irq_done_e0: got %b expected 0", exc_done); end
        exc_code = 3'd6; exc_lr = 32'h999;
        w_en = 2'b01; w_addr[3:0] = 4'd0; w_data[31:0] = 32'hFFFFFFFF; w_byte_en[3:0] = 4'hF;
        PC_write_en = 1'b1; PC_in = 32'h777;
        CPSR_write_en = 1'b1; CPSR_in = 32'h1F;
        SPSR_write_en = 1'b1; SPSR_in = 32'h55;
        exc_ret_req = 1'b1; exc_ret_pc = 32'h5555;
        tick();
        n_cmp++; if (CPSR_out !== 32'h10) begin n_fail++; $display("FAIL irq_cpsr_e1: got %h expected 10", CPSR_out); end
        n_cmp++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL irq_pc_e1: got %h expected 0", PC_out); end
        tick();
        n_cmp++; if (CPSR_out !== 32'h92) begin n_fail++; $display("FAIL irq_cpsr_e2: got %h expected 92", CPSR_out); end
        n_cmp++; if (PC_out !== 32'h18) begin n_fail++; $display("FAIL irq_pc_e2: got %h expected 18", PC_out); end
        n_cmp++; if (SPSR_out !== 32'h10) begin n_fail++; $display("FAIL irq_spsr: got %h expected 10", SPSR_out); end
        n_cmp++; if (r_data[31:0] !== 32'h104) begin n_fail++; $display("FAIL irq_lr: got %h expected 104", r_data[31:0]); end
        n_cmp++; if (exc_done !== 1'b1) begin n_fail++; $display("FAIL irq_done_e2: got %b expected 1", exc_done); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (exc_done !== 1'b0) begin n_fail++; $display("FAIL irq_done_e3: got %b expected 0", exc_done); end
        n_cmp++; if (exc_busy !== 1'b0) begin n_fail++; $display("FAIL irq_busy_e3: got %b expected 0", exc_busy); end
        n_cmp++; if (SPSR_out !== 32'h10) begin n_fail++; $display("FAIL irq_spsr_blocked: got %h expected 10", SPSR_out); end
        n_cmp++; if (r_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL irq_r0_blocked: got %h expected 0", r_data[63:32]); end
        n_cmp++; if (CPSR_out !== 32'h92) begin n_fail++; $display("FAIL irq_cpsr_e3: got %h expected 92", CPSR_out); end
        tick();
        n_cmp++; if (exc_busy !== 1'b0) begin n_fail++; $display("FAIL irq_not_queued: got %b expected 0", exc_busy); end
    endtask

    task automatic test_return();
        exc_ret_req = 1'b1; exc_ret_pc = 32'h100;
        CPSR_write_en = 1'b1; CPSR_in = 32'h1F;
        PC_write_en = 1'b1; PC_in = 32'h999;
        tick();
        clear_inputs();
        n_cmp++; if (CPSR_out !== 32'h10) begin n_fail++; $display("FAIL ret_cpsr: got %h expected 10", CPSR_out); end
        n_cmp++; if (PC_out !== 32'h100) begin n_fail++; $display("FAIL ret_pc: got %h expected 100", PC_out); end
        n_cmp++; if (exc_busy !== 1'b0) begin n_fail++; $display("FAIL ret_busy: got %b expected 0", exc_busy); end
        r_addr = {4'd0, 4'd0, 4'd0, 4'd14};
        exc_req = 1'b1; exc_code = 3'd2; exc_lr = 32'h200;
        exc_ret_req = 1'b1; exc_ret_pc = 32'h300;
        tick();
        clear_inputs();
        n_cmp++; if (exc_busy !== 1'b1) begin n_fail++; $display("FAIL swi_busy: got %b expected 1", exc_busy); end
        n_cmp++; if (PC_out !== 32'h100) begin n_fail++; $display("FAIL swi_ret_dropped: got %h expected 100", PC_out); end
        tick();
        tick();
        n_cmp++; if (CPSR_out !== 32'h93) begin n_fail++; $display("FAIL swi_cpsr: got %h expected 93", CPSR_out); end
        n_cmp++; if (PC_out !== 32'h08) begin n_fail++; $display("FAIL swi_pc: got %h expected 08", PC_out); end
        n_cmp++; if (SPSR_out !== 32'h10) begin n_fail++; $display("FAIL swi_spsr: got %h expected 10", SPSR_out); end
        n_cmp++; if (r_data[31:0] !== 32'h200) begin n_fail++; $display("FAIL swi_lr: got %h expected 200", r_data[31:0]); end
        tick();
        n_cmp++; if (exc_busy !== 1'b0) begin n_fail++; $display("FAIL swi_idle: got %b expected 0", exc_busy); end
    endtask

    task automatic test_reset_mid();
        exc_req = 1'b1; exc_code = 3'd6; exc_lr = 32'h44;
        tick();
        clear_inputs();
        tick();
        n_cmp++; if (exc_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_switch: got %b expected 1", exc_busy); end
        Rst = 1'b0;
        #1;
        n_cmp++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL mid_pc: got %h expected 0", PC_out); end
        n_cmp++; if (CPSR_out !== 32'hD3) begin n_fail++; $display("FAIL mid_cpsr: got %h expected D3", CPSR_out); end
        n_cmp++; if (exc_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", exc_busy); end
        n_cmp++; if (SPSR_out !== 32'h0) begin n_fail++; $display("FAIL mid_spsr: got %h expected 0", SPSR_out); end
        n_cmp++; if (r_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL mid_lr: got %h expected 0", r_data[31:0]); end
        tick();
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (exc_done !== 1'b0 || exc_busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_release[%0d]: got done=%b busy=%b expected 0 0", i, exc_done, exc_busy); end
        end
    endtask

    task automatic test_fiq_und_entry();
        r_addr = {4'd0, 4'd0, 4'd0, 4'd14};
        exc_req = 1'b1; exc_code = 3'd6; exc_lr = 32'h44;
        tick();
        clear_inputs();
        tick();
        tick();
        n_cmp++; if (CPSR_out !== 32'hD1) begin n_fail++; $display("FAIL fiq_cpsr: got %h expected D1", CPSR_out); end
        n_cmp++; if (PC_out !== 32'h1C) begin n_fail++; $display("FAIL fiq_pc: got %h expected 1C", PC_out); end
        n_cmp++; if (SPSR_out !== 32'hD3) begin n_fail++; $display("FAIL fiq_spsr: got %h expected D3", SPSR_out); end
        n_cmp++; if (r_data[31:0] !== 32'h44) begin n_fail++; $display("FAIL fiq_lr: got %h expected 44", r_data[31:0]); end
        tick();
        exc_req = 1'b1; exc_code = 3'd7; exc_lr = 32'h7;
        tick();
        clear_inputs();
        tick();
        tick();
        n_cmp++; if (CPSR_out !== 32'hDB) begin n_fail++; $display("FAIL und7_cpsr: got %h expected DB", CPSR_out); end
        n_cmp++; if (PC_out !== 32'h04) begin n_fail++; $display("FAIL und7_pc: got %h expected 04", PC_out); end
        n_cmp++; if (SPSR_out !== 32'hD1) begin n_fail++; $display("FAIL und7_spsr: got %h expected D1", SPSR_out); end
        n_cmp++; if (r_data[31:0] !== 32'h7) begin n_fail++; $display("FAIL und7_lr: got %h expected 7", r_data[31:0]); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        Rst = 1'b0;
        r_addr = '0;
        clear_inputs();
        test_reset();
        test_banking();
        test_bypass();
        test_irq_entry();
        test_return();
        test_reset_mid();
        test_fiq_und_entry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_banked_regs.md
Name: arm_banked_regs

Overview:
- Next-generation ARM register file with mode banking.
- Generalises read/write port counts and data width.
- Adds same-cycle write bypass and a built-in exception-entry/return sequencer. Entry saves CPSR to the target SPSR, writes the banked LR, switches mode and loads the vector PC.
- Sits between decode/writeback and the core control FSM; replaces the flat banked wrapper.

Parameters:
- DATA_WIDTH, 32, register width in bits (multiple of 8).
- ADDR_WIDTH, 4, logical register address width (R0..R15).
- NUM_READ, 4, number of read ports.
- NUM_WRITE, 2, number of write ports; higher index has higher priority.
- MODE_WIDTH, 5, CPSR mode field width.
- BYPASS, 1, 1 = reads return same-cycle write data; 0 = registered value only.
- VECTOR_BASE, 32'h0000_0000, exception vector base (32'hFFFF_0000 for high vectors).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- r_addr  in  NUM_READ*ADDR_WIDTH  packed logical read addresses.
- r_data  out  NUM_READ*DATA_WIDTH  packed read data, combinational.
- w_en  in  NUM_WRITE  per-port write enable.
- w_addr  in  NUM_WRITE*ADDR_WIDTH  packed logical write addresses.
- w_data  in  NUM_WRITE*DATA_WIDTH  packed write data.
- w_byte_en  in  NUM_WRITE*DATA_WIDTH/8  packed byte enables.
- PC_in  in  DATA_WIDTH  next PC.
- PC_write_en  in  1  PC write.
- PC_out  out  DATA_WIDTH  current PC.
- CPSR_in  in  DATA_WIDTH  CPSR write data.
- CPSR_write_en  in  1  CPSR write.
- CPSR_byte_w_en  in  DATA_WIDTH/8  CPSR byte enables.
- CPSR_out  out  DATA_WIDTH  current CPSR.
- SPSR_in  in  DATA_WIDTH  SPSR write data (current mode's bank).
- SPSR_write_en  in  1  SPSR write.
- SPSR_byte_w_en  in  DATA_WIDTH/8  SPSR byte enables.
- SPSR_out  out  DATA_WIDTH  current mode's SPSR (0 in USR/SYS).
- Mode_out  out  MODE_WIDTH  CPSR[MODE_WIDTH-1:0].
- exc_req  in  1  exception entry request, level.
- exc_code  in  3  0 RST, 1 UND, 2 SWI, 3 PABT, 4 DABT, 5 IRQ, 6 FIQ; 7 is treated as UND.
- exc_lr  in  DATA_WIDTH  value to write into the target banked R14.
- exc_ret_req  in  1  exception return request.
- exc_ret_pc  in  DATA_WIDTH  return PC.
- exc_busy  out  1  sequencer active.
- exc_done  out  1  one-cycle pulse when entry completes.

Behaviour:
- Storage:
  - 31 physical GPRs: 16 USR, FIQ R8-R14, and R13-R14 for each of IRQ/SVC/ABT/UND.
  - 5 SPSRs (FIQ/IRQ/SVC/ABT/UND), PC, CPSR.
- Logical-to-physical mapping uses the current CPSR mode. Unknown modes and SYS map to the USR bank.
- R15 handling:
  - Reads of logical R15 return PC_out.
  - Write-port writes to R15 are ignored; PC changes only via PC_in or the sequencer.
- Reset (Rst low, async): all GPRs 0, SPSRs 0, PC 0, CPSR 32'h0000_00D3 (SVC, I=F=1), FSM IDLE, exc_busy 0, exc_done 0.
- Write ports (byte-masked) update at the rising edge.
  - Two ports hitting the same physical register: per byte, the highest-index enabled port wins.
- Bypass (BYPASS=1): a read whose physical index matches an enabled write gets, per byte, the winning write byte; otherwise the stored byte. BYPASS=0: stored value only.
- FSM states: IDLE, SAVE, SWITCH, DONE. exc_busy = 1 in SAVE, SWITCH and DONE.
- IDLE:
  - exc_req=1: latch exc_code and exc_lr, then go to SAVE. Normal writes in this cycle still apply.
  - Otherwise, exc_ret_req=1: at the edge, CPSR <= current SPSR (CPSR unchanged if USR/SYS) and PC <= exc_ret_pc. Same-cycle CPSR_write_en and PC_write_en lose. Stay in IDLE.
  - exc_req and exc_ret_req together: entry wins; the return is dropped.
- SAVE: target-mode SPSR <= CPSR (value at this edge); target-bank R14 <= latched exc_lr; go to SWITCH.
- SWITCH:
  - CPSR[4:0] <= target mode, CPSR[5] (T) <= 0, CPSR[7] (I) <= 1; CPSR[6] (F) <= 1 for RST/FIQ, else unchanged.
  - PC <= VECTOR_BASE + offset; go to DONE.
- DONE: exc_done = 1 for this cycle only; go to IDLE.
- Exception mode and vector table:
  - RST: SVC, offset 0x00.
  - UND: UND (0x1B), offset 0x04.
  - SWI: SVC (0x13), offset 0x08.
  - PABT: ABT (0x17), offset 0x0C.
  - DABT: ABT, offset 0x10.
  - IRQ: IRQ (0x12), offset 0x18.
  - FIQ: FIQ (0x11), offset 0x1C.
- While exc_busy:
  - All external writes (w_en, PC/CPSR/SPSR_write_en) are ignored.
  - exc_req and exc_ret_req are ignored and not queued.
  - Reads stay live, mapped by the current CPSR.
- Latency: request accepted at edge 0; SPSR/LR written at edge 1; CPSR/PC written at edge 2; exc_done high between edges 2 and 3.
- Reset mid-sequence: immediately returns to the reset state; no partial state survives.

Decomposition:
- Package arm_reg_pkg:
  - Mode constants (USR/FIQ/IRQ/SVC/ABT/UND/SYS).
  - exc_code enum and vector-offset/target-mode lookup functions.
  - Physical index constants and the SPSR index function.
- Sub-module arm_bank_map: combinational (logical addr, mode) -> 5-bit physical index. Instantiated once per read and write port, plus once for the target-mode LR.

Test Plan:
- Reset: after Rst low, CPSR_out=32'hD3, PC_out=0, every r_data=0, exc_busy=0.
- Banking:
  - In USR (CPSR=0x10), write R13=0x1111.
  - Switch CPSR to IRQ (0x12), write R13=0x2222.
  - Back to USR, read R13 -> 0x1111.
  - In FIQ (0x11), read R8 -> 0, not the USR R8.
- Bypass and conflicts:
  - Port0 writes R3=0xAAAAAAAA, port1 writes R3=0x000000BB with byte_en=4'b0001 in the same cycle.
  - A same-cycle read of R3 gives 0xAAAAAABB; the stored value after the edge is 0xAAAAAABB.
- IRQ entry from USR:
  - CPSR=0x10, exc_code=5, exc_lr=0x104, VECTOR_BASE=0.
  - IRQ SPSR=0x10 and IRQ R14=0x104 after edge 1.
  - CPSR=0x92 and PC=0x18 after edge 2.
  - exc_done pulses exactly one cycle; w_en during busy has no effect.
- Return: from IRQ with SPSR=0x10, exc_ret_req with exc_ret_pc=0x100 -> next cycle CPSR=0x10, PC=0x100. A same-cycle exc_req instead wins and starts entry.
- Async reset asserted during SWITCH -> PC=0, CPSR=0xD3, exc_busy=0 immediately; no exc_done pulse after release.
